uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised successor to the fixed 8-bit UART transmitter with its separate divide-by-164 toggle clock.
- Runs entirely on the system clock and generates its own bit timing internally, so no derived clock is needed.
- Configurable frame format: data width, parity mode and stop-bit count.
- Valid/ready input with a one-entry holding buffer, so consecutive frames go out with no idle gap.
- Sits between the board top (DIP/data source or processor bus) and the serial tx pin.

Parameters:
- CLKS_PER_BIT, 5248, clk cycles per serial bit. Legal range >= 2.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  word to transmit; sampled only on a handshake cycle.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding buffer empty, word can be accepted.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high when a frame is in progress or the buffer is full.
- frame_done  output  1  one-cycle pulse when the final stop bit of a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, tx_ready=1, busy=0, frame_done=0.
  - Buffer emptied, FSM to IDLE, baud counter cleared.
  - Applies immediately, including mid-frame; the partial frame is abandoned with no frame_done.
- Handshake:
  - A transfer occurs on a rising edge where tx_valid && tx_ready; tx_data is latched into the holding buffer.
  - tx_ready is registered and equals ~buf_full; there is no combinational path from tx_valid.
  - tx_data is ignored while tx_ready=0.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state; it is held at 0 in IDLE.
  - A bit ends when the count equals CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if buf_full, load the shift register from the buffer, clear buf_full, go to START.
    - Accept at edge E0 → tx falls at E1.
    - tx_ready returns high after E1, so a second word can be queued during the frame.
  - START: tx=0 for one bit time, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, one bit time each. Then go to PAR if PARITY!=0, else STOP.
  - PAR: one bit time.
    - Even parity: tx = XOR of the data bits.
    - Odd parity: tx = inverted XOR of the data bits.
  - STOP: tx=1 for STOP_BITS bit times.
    - On the last cycle of the stop period, frame_done=1 for exactly one cycle.
    - If buf_full at that cycle: load and go directly to START. tx is low on the very next cycle, with no extra idle cycle.
    - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Handshake and buffer refill coinciding: if a handshake and the STOP→START reload happen on the same edge, the buffer refills from the new word while the old word moves to the shift register. No data is lost.
- busy = (state != IDLE) || buf_full.
- Illegal parameter values raise $error at elaboration.

Decomposition:
- Shared package uart_pkg contains:
  - enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD};
  - enum tx_state_e {IDLE, START, DATA, PAR, STOP};
  - localparam DEFAULT_CLKS_PER_BIT = 5248.
- Sub-module uart_baud_gen: counter with clear/enable inputs and a bit_end tick output. It is reused by the future uart_rx_cfg at a 16x rate.
- Top level holds the FSM, holding buffer, shift register, bit index and parity accumulator.

Test Plan:
1. Reset hold, 10 cycles with reset=0 → tx=1, tx_ready=1, busy=0, frame_done=0 every cycle.
2. CLKS_PER_BIT=4, 8N1, send 0xA5 → expected response:
   - tx low one cycle after accept, for 4 cycles.
   - Then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles.
   - One frame_done pulse at cycle 40 of the frame.
3. CLKS_PER_BIT=4, 7 data bits, 2 stop bits, send 0x07:
   - With PARITY=1, parity bit = 1.
   - With PARITY=2, parity bit = 0.
   - Frame = 44 cycles, stop high for 8 cycles.
4. Back-to-back: tx_valid held high presenting 0x55 then 0xAA →
   - Second word accepted one cycle after the first loads; tx_ready low until the reload.
   - Start bit of 0xAA begins the cycle after the 0x55 frame_done; busy stays high throughout.
5. Backpressure: while tx_ready=0, change tx_data every cycle → only the value present on the handshake edge is transmitted.
6. Assert reset mid-DATA at bit 3 →
   - tx=1 immediately, tx_ready=1, no frame_done.
   - After release, a fresh 0x3C frame is transmitted bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the configurable UART blocks
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;
  localparam int DEFAULT_CLKS_PER_BIT = 5248;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: wrapping bit-period counter with a tick on the last cycle of each period
module uart_baud_gen #(
  parameter int CLKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  localparam int W = $clog2(CLKS);
  logic [W-1:0] cnt;
  assign bit_end = en && cnt == W'(CLKS - 1);
  // count 0..CLKS-1 while enabled, held at zero while cleared
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a one-word holding buffer
module uart_tx_cfg import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  localparam logic HAS_PAR = PARITY != int'(PAR_NONE);
  localparam logic ODD     = PARITY == int'(PAR_ODD);
  tx_state_e state, state_n;
  logic buf_full, buf_full_n, par_acc, par_n, load, shift, bit_end, hs, tx_d, last_data, last_stop;
  logic [DATA_BITS-1:0] buf_data, shreg, shreg_n;
  logic [3:0] idx, idx_n;
  uart_baud_gen #(.CLKS(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );
  assign hs        = tx_valid && tx_ready;
  assign busy      = state != IDLE || buf_full;
  assign last_data = idx == 4'(DATA_BITS - 1);
  assign last_stop = idx == 4'(STOP_BITS - 1);
  // frame sequencing; a stop period with a queued word chains straight into the next start bit
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    shift      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (buf_full) begin
               load    = 1'b1;
               state_n = START;
             end
      START: if (bit_end) state_n = DATA;
      DATA:  if (bit_end) begin
               shift = 1'b1;
               if (last_data) state_n = HAS_PAR ? PAR : STOP;
             end
      PAR:   if (bit_end) state_n = STOP;
      STOP:  if (bit_end && last_stop) begin
               frame_done = 1'b1;
               load       = buf_full;
               state_n    = buf_full ? START : IDLE;
             end
      default: state_n = IDLE;
    endcase
  end
  // datapath next values; tx is registered from the next state so it moves on the same edge
  always_comb begin
    shreg_n    = load ? buf_data : shift ? shreg >> 1 : shreg;
    par_n      = load ? 1'b0 : shift ? par_acc ^ shreg[0] : par_acc;
    idx_n      = (load || (shift && last_data)) ? '0 : (shift || (bit_end && state == STOP)) ? idx + 4'd1 : idx;
    buf_full_n = hs || (buf_full && !load);
    tx_d       = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PAR ? par_n ^ ODD : 1'b1;
  end
  // state, buffer and line registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      shreg    <= '0;
      idx      <= '0;
      par_acc  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      state    <= state_n;
      buf_full <= buf_full_n;
      if (hs) buf_data <= tx_data;
      shreg    <= shreg_n;
      idx      <= idx_n;
      par_acc  <= par_n;
      tx       <= tx_d;
      tx_ready <= !buf_full_n;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of frame format, handshake, chaining and reset
module tb_uart_tx_cfg;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] td0 = '0;
  logic [6:0] td1 = '0, td2 = '0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic r0, r1, r2, tx0, tx1, tx2, b0, b1, b2, f0, f1, f2;
  logic o_tx, o_rdy, o_busy, o_fd;
  int sel = 0, tests = 0, fails = 0;
  logic q_tx[$], q_fd[$];
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_data(td0), .tx_valid(v0), .tx_ready(r0), .tx(tx0), .busy(b0), .frame_done(f0));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .tx_data(td1), .tx_valid(v1), .tx_ready(r1), .tx(tx1), .busy(b1), .frame_done(f1));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .tx_data(td2), .tx_valid(v2), .tx_ready(r2), .tx(tx2), .busy(b2), .frame_done(f2));
  assign o_tx   = sel == 0 ? tx0 : sel == 1 ? tx1 : tx2;
  assign o_rdy  = sel == 0 ? r0 : sel == 1 ? r1 : r2;
  assign o_busy = sel == 0 ? b0 : sel == 1 ? b1 : b2;
  assign o_fd   = sel == 0 ? f0 : sel == 1 ? f1 : f2;
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic drive(input int s, input logic [8:0] d, input logic v);
    if (s == 0) begin td0 = d[7:0]; v0 = v; end
    else if (s == 1) begin td1 = d[6:0]; v1 = v; end
    else begin td2 = d[6:0]; v2 = v; end
  endtask
  // expected per-cycle line and frame_done for one frame at 4 clocks per bit
  function automatic void add_frame(input logic [8:0] d, input int nd, input int par, input int ns);
    logic bits[$];
    logic p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (par != 0) bits.push_back(par == 2 ? ~p : p);
    for (int i = 0; i < ns; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++)
      for (int j = 0; j < 4; j++) begin
        q_tx.push_back(bits[i]);
        q_fd.push_back(i == bits.size() - 1 && j == 3);
      end
  endfunction
  task automatic step(input int k);
    @(negedge clk);
    chk($sformatf("tx c%0d", k), o_tx, q_tx.pop_front());
    chk($sformatf("frame_done c%0d", k), o_fd, q_fd.pop_front());
    chk($sformatf("busy c%0d", k), o_busy, 1'b1);
  endtask
  task automatic send_single(input int s, input logic [8:0] d, input int nd, input int par, input int ns);
    sel = s;
    @(negedge clk);
    chk("ready before accept", o_rdy, 1'b1);
    drive(s, d, 1'b1);
    @(negedge clk);
    chk("ready after accept", o_rdy, 1'b0);
    chk("tx idle at accept", o_tx, 1'b1);
    drive(s, d, 1'b0);
    add_frame(d, nd, par, ns);
    for (int k = 1; k <= (2 + nd + (par != 0) + ns) * 4 - 4; k++) step(k);
    @(negedge clk);
    chk("busy after frame", o_busy, 1'b0);
    chk("tx idle after frame", o_tx, 1'b1);
    chk("no extra frame_done", o_fd, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [8:0] rnd;
    repeat (10) begin
      @(negedge clk);
      chk("reset tx", tx0, 1'b1);
      chk("reset ready", r0, 1'b1);
      chk("reset busy", b0, 1'b0);
      chk("reset frame_done", f0, 1'b0);
      chk("reset tx u1", tx1, 1'b1);
      chk("reset tx u2", tx2, 1'b1);
    end
    reset = 1'b1;
    send_single(0, 9'h0A5, 8, 0, 1);
    send_single(1, 9'h007, 7, 1, 2);
    send_single(2, 9'h007, 7, 2, 2);
    sel = 0;
    @(negedge clk);
    drive(0, 9'h055, 1'b1);
    @(negedge clk);
    chk("b2b ready c0", o_rdy, 1'b0);
    drive(0, 9'h0AA, 1'b1);
    add_frame(9'h055, 8, 0, 1);
    add_frame(9'h0AA, 8, 0, 1);
    step(1);
    chk("b2b ready c1", o_rdy, 1'b1);
    step(2);
    chk("b2b ready c2", o_rdy, 1'b0);
    drive(0, 9'h0AA, 1'b0);
    for (int k = 3; k <= 80; k++) begin
      step(k);
      if (k == 40) chk("b2b ready before reload", o_rdy, 1'b0);
      if (k == 41) chk("b2b ready after reload", o_rdy, 1'b1);
    end
    @(negedge clk);
    chk("b2b busy after", o_busy, 1'b0);
    @(negedge clk);
    drive(0, 9'h081, 1'b1);
    @(negedge clk);
    chk("bp ready c0", o_rdy, 1'b0);
    drive(0, 9'h03E, 1'b1);
    add_frame(9'h081, 8, 0, 1);
    add_frame(9'h03E, 8, 0, 1);
    step(1);
    step(2);
    chk("bp ready c2", o_rdy, 1'b0);
    for (int k = 3; k <= 40; k++) begin
      step(k);
      rnd = 9'($urandom);
      drive(0, rnd, k != 40);
    end
    for (int k = 41; k <= 80; k++) step(k);
    @(negedge clk);
    chk("bp busy after", o_busy, 1'b0);
    @(negedge clk);
    drive(0, 9'h0C3, 1'b1);
    @(negedge clk);
    drive(0, 9'h0C3, 1'b0);
    add_frame(9'h0C3, 8, 0, 1);
    for (int k = 1; k <= 18; k++) step(k);
    reset = 1'b0;
    #1;
    chk("midreset tx", o_tx, 1'b1);
    chk("midreset ready", o_rdy, 1'b1);
    chk("midreset busy", o_busy, 1'b0);
    chk("midreset frame_done", o_fd, 1'b0);
    q_tx.delete();
    q_fd.delete();
    repeat (3) begin
      @(negedge clk);
      chk("held reset frame_done", o_fd, 1'b0);
      chk("held reset tx", o_tx, 1'b1);
    end
    reset = 1'b1;
    send_single(0, 9'h03C, 8, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
